// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types and default widths for the ROM fetch arbiter and its tag pipeline.
package fetch_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 24;

    typedef enum logic {
        OWN_DISP,
        OWN_AUX
    } owner_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_e;

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Bundle of the FIFO write side, ROM read port and aux client signals around the arbiter.
interface rom_fetch_arbiter_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              frame_start;
    logic              fifo_afull;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_din;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              aux_req;
    logic [ADDR_W-1:0] aux_addr;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;
    logic              frame_done;
    logic              busy;

    // Environment side: drives requests, FIFO status and ROM data.
    modport master (
        output frame_start, fifo_afull, rom_dout, aux_req, aux_addr,
        input  fifo_wr_en, fifo_din, rom_addr, aux_gnt, aux_rvalid, aux_rdata,
               frame_done, busy
    );

    // Arbiter side.
    modport slave (
        input  frame_start, fifo_afull, rom_dout, aux_req, aux_addr,
        output fifo_wr_en, fifo_din, rom_addr, aux_gnt, aux_rvalid, aux_rdata,
               frame_done, busy
    );
endinterface

// File: rtl/rom_fetch_arbiter_tag_pipe.sv
// ROM_LAT-deep shift register of {valid, owner} tags that follows each ROM read
// so the data arriving at the ROM output can be routed to its requester.
module fetch_tag_pipe
    import fetch_pkg::*;
#(
    parameter int ROM_LAT = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  owner_e in_owner,
    input  logic   flush_disp,
    output logic   out_valid,
    output owner_e out_owner,
    output logic   any_disp_inflight
);
    // Stages that have not yet reached the output; the exit stage is excluded.
    localparam logic [ROM_LAT-1:0] BEHIND_MASK = {ROM_LAT{1'b1}} >> 1;

    logic [ROM_LAT-1:0] valid_q;
    owner_e             owner_q [ROM_LAT];
    logic [ROM_LAT-1:0] disp_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            owner_q <= '{default: OWN_DISP};
        end else begin
            valid_q[0] <= in_valid;
            owner_q[0] <= in_owner;
            // A flush drops display tags as they shift; aux tags always survive.
            for (int i = 1; i < ROM_LAT; i++) begin
                valid_q[i] <= valid_q[i-1] && !(flush_disp && owner_q[i-1] == OWN_DISP);
                owner_q[i] <= owner_q[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROM_LAT; gi++) begin : g_disp
            assign disp_vec[gi] = valid_q[gi] && (owner_q[gi] == OWN_DISP);
        end
    endgenerate

    assign out_valid         = valid_q[ROM_LAT-1];
    assign out_owner         = owner_q[ROM_LAT-1];
    assign any_disp_inflight = |(disp_vec & BEHIND_MASK);

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Frame-aware display fetch engine sharing one ROM read port with an aux reader;
// the aux side gets a guaranteed slot after AUX_STARVE consecutive denials.
module rom_fetch_arbiter
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FRAME_WORDS = 4800,
    parameter int ROM_LAT     = 2,
    parameter int AUX_STARVE  = 8
) (
    input  logic                clk,
    input  logic                rst,
    rom_fetch_arbiter_if.slave  bus
);
    localparam int                SW        = $clog2(AUX_STARVE + 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [SW-1:0]     STARVE_MAX = SW'(AUX_STARVE);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [SW-1:0]     starve_q;

    logic              disp_elig;
    logic              aux_win;
    logic              disp_win;
    logic              tag_out_valid;
    owner_e            tag_out_owner;
    logic              disp_inflight;
    logic              exit_disp;
    logic              exit_aux;
    logic              last_retire;
    logic [DATA_W-1:0] rd_data;

    // A restart pulse blocks display issue so the first new-frame address goes out next cycle.
    always_comb begin
        disp_elig = (state_q == FETCH) && !bus.fifo_afull && !bus.frame_start;
        aux_win   = bus.aux_req && (!disp_elig || (starve_q == STARVE_MAX));
        disp_win  = disp_elig && !aux_win;
        if (aux_win) begin
            rom_addr_d = bus.aux_addr;
        end else if (disp_win) begin
            rom_addr_d = cnt_q;
        end else begin
            rom_addr_d = rom_addr_q;
        end
    end

    fetch_tag_pipe #(
        .ROM_LAT (ROM_LAT)
    ) u_tag_pipe (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (aux_win || disp_win),
        .in_owner          (aux_win ? OWN_AUX : OWN_DISP),
        .flush_disp        (bus.frame_start),
        .out_valid         (tag_out_valid),
        .out_owner         (tag_out_owner),
        .any_disp_inflight (disp_inflight)
    );

    // The display tag exiting during a restart belongs to the aborted frame.
    assign exit_disp   = tag_out_valid && (tag_out_owner == OWN_DISP) && !bus.frame_start;
    assign exit_aux    = tag_out_valid && (tag_out_owner == OWN_AUX);
    assign last_retire = (state_q == DRAIN) && exit_disp && !disp_inflight;
    assign rd_data     = bus.rom_dout;

    assign bus.rom_addr   = rom_addr_d;
    assign bus.aux_gnt    = aux_win;
    assign bus.fifo_wr_en = exit_disp;
    assign bus.fifo_din   = exit_disp ? rd_data : '0;
    assign bus.aux_rvalid = exit_aux;
    assign bus.aux_rdata  = exit_aux ? rd_data : '0;
    assign bus.frame_done = last_retire;
    assign bus.busy       = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            starve_q   <= '0;
        end else begin
            if (aux_win || disp_win) begin
                rom_addr_q <= rom_addr_d;
            end

            if (aux_win) begin
                starve_q <= '0;
            end else if (bus.aux_req && (starve_q != STARVE_MAX)) begin
                starve_q <= starve_q + 1'b1;
            end

            if (bus.frame_start) begin
                state_q <= FETCH;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (disp_win) begin
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == LAST_WORD) begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (last_retire) begin
                            state_q <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed self-checking bench for rom_fetch_arbiter with a 2-cycle-latency ROM model.
module tb_rom_fetch_arbiter;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    int wr_next;
    int wr_err;
    int done_cnt;
    int aux_cnt;

    rom_fetch_arbiter_if #(.ADDR_W(13), .DATA_W(24)) bus ();

    rom_fetch_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] rom_word(input logic [12:0] a);
        return {a[7:0] ^ 8'hA5, 3'b101, a};
    endfunction

    logic [23:0] rd0, rd1;
    always @(posedge clk) begin
        rd0 <= rom_word(bus.rom_addr);
        rd1 <= rd0;
    end
    assign bus.rom_dout = rd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        if (bus.fifo_wr_en === 1'b1) begin
            if (bus.fifo_din !== rom_word(wr_next[12:0])) wr_err++;
            wr_next++;
        end
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.aux_rvalid === 1'b1) aux_cnt++;
    endtask

    task automatic clear_mon();
        wr_next  = 0;
        wr_err   = 0;
        done_cnt = 0;
        aux_cnt  = 0;
    endtask

    // Full unobstructed frame; the frame_start pulse was issued in the previous cycle.
    task automatic run_plain(input string pfx);
        int addr_err;
        addr_err = 0;
        bus.frame_start = 1'b0;
        clear_mon();
        for (int k = 0; k <= 4802; k++) begin
            sample();
            if (k < 4800 && bus.rom_addr !== 13'(k)) addr_err++;
            if (k == 0) check($sformatf("%s_first_addr", pfx), 32'(bus.rom_addr), 0);
            if (k == 1) check($sformatf("%s_no_early_wr", pfx), 32'(bus.fifo_wr_en), 0);
            if (k == 2) begin
                check($sformatf("%s_first_wr", pfx), 32'(bus.fifo_wr_en), 1);
                check($sformatf("%s_first_data", pfx), 32'(bus.fifo_din), 32'(rom_word(13'd0)));
            end
            if (k == 4801) check($sformatf("%s_done_pulse", pfx), 32'(bus.frame_done), 1);
            if (k == 4802) check($sformatf("%s_idle_after", pfx), 32'(bus.busy), 0);
            adv();
        end
        check($sformatf("%s_addr_seq_errs", pfx), 32'(addr_err), 0);
        check($sformatf("%s_wr_count", pfx), 32'(wr_next), 4800);
        check($sformatf("%s_wr_data_errs", pfx), 32'(wr_err), 0);
        check($sformatf("%s_done_count", pfx), 32'(done_cnt), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int addr_err;
        int win_wr;
        int exp_a;
        int gnt_k;
        logic aux_pending;
        logic wr_seen;
        logic busy_seen;

        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.fifo_afull  = 1'b0;
        bus.aux_req     = 1'b0;
        bus.aux_addr    = '0;
        clear_mon();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rom_addr", 32'(bus.rom_addr), 0);
        check("rst_fifo_wr_en", 32'(bus.fifo_wr_en), 0);
        check("rst_fifo_din", 32'(bus.fifo_din), 0);
        check("rst_aux_gnt", 32'(bus.aux_gnt), 0);
        check("rst_aux_rvalid", 32'(bus.aux_rvalid), 0);
        check("rst_aux_rdata", 32'(bus.aux_rdata), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        adv();
        rst = 1'b0;

        // Plain frame
        bus.frame_start = 1'b1;
        sample();
        check("f1_start_cycle_busy", 32'(bus.busy), 0);
        adv();
        run_plain("f1");

        // Backpressure at address 300 for 20 cycles
        bus.frame_start = 1'b1;
        sample();
        adv();
        bus.frame_start = 1'b0;
        clear_mon();
        addr_err = 0;
        win_wr   = 0;
        for (int k = 0; k <= 4822; k++) begin
            bus.fifo_afull = (k >= 300 && k < 320);
            sample();
            exp_a = (k < 300) ? k : ((k < 320) ? 299 : k - 20);
            if (k < 4820 && bus.rom_addr !== 13'(exp_a)) addr_err++;
            if (k >= 300 && k < 320 && bus.fifo_wr_en === 1'b1) win_wr++;
            if (k == 300) check("bp_hold_addr", 32'(bus.rom_addr), 299);
            if (k == 301) check("bp_last_trailing", 32'(bus.fifo_din), 32'(rom_word(13'd299)));
            if (k == 302) check("bp_no_third_write", 32'(bus.fifo_wr_en), 0);
            if (k == 320) check("bp_resume_addr", 32'(bus.rom_addr), 300);
            if (k == 4821) check("bp_done_pulse", 32'(bus.frame_done), 1);
            if (k == 4822) check("bp_idle_after", 32'(bus.busy), 0);
            adv();
        end
        bus.fifo_afull = 1'b0;
        check("bp_addr_seq_errs", 32'(addr_err), 0);
        check("bp_window_writes", 32'(win_wr), 2);
        check("bp_wr_count", 32'(wr_next), 4800);
        check("bp_wr_data_errs", 32'(wr_err), 0);
        check("bp_done_count", 32'(done_cnt), 1);

        // Starvation during FETCH, then restart at display address 100
        bus.frame_start = 1'b1;
        sample();
        adv();
        bus.frame_start = 1'b0;
        bus.aux_addr    = 13'h1ABC;
        clear_mon();
        addr_err    = 0;
        gnt_k       = -1;
        aux_pending = 1'b0;
        for (int k = 0; k <= 101; k++) begin
            if (k == 10) aux_pending = 1'b1;
            bus.aux_req     = aux_pending;
            bus.frame_start = (k == 101);
            sample();
            if (bus.aux_gnt === 1'b1) begin
                if (gnt_k < 0) gnt_k = k;
                aux_pending = 1'b0;
            end
            exp_a = (k < 18) ? k : ((k == 18) ? 32'h1ABC : ((k <= 100) ? k - 1 : 99));
            if (bus.rom_addr !== 13'(exp_a)) addr_err++;
            if (k == 18) check("starve_gnt_addr", 32'(bus.rom_addr), 32'h1ABC);
            if (k == 19) check("starve_no_skip", 32'(bus.rom_addr), 18);
            if (k == 20) begin
                check("starve_rvalid", 32'(bus.aux_rvalid), 1);
                check("starve_rdata", 32'(bus.aux_rdata), 32'(rom_word(13'h1ABC)));
                check("starve_no_fifo_wr", 32'(bus.fifo_wr_en), 0);
            end
            if (k == 101) check("rs_kill_exiting", 32'(bus.fifo_wr_en), 0);
            adv();
        end
        bus.aux_req = 1'b0;
        check("starve_gnt_cycle", 32'(gnt_k), 18);
        check("starve_rvalid_count", 32'(aux_cnt), 1);
        check("rs_addr_seq_errs", 32'(addr_err), 0);
        check("rs_prior_writes", 32'(wr_next), 98);
        check("rs_prior_data_errs", 32'(wr_err), 0);

        // Restarted frame; a second restart lands on its final retire
        bus.frame_start = 1'b0;
        clear_mon();
        addr_err = 0;
        for (int k = 0; k <= 4801; k++) begin
            bus.frame_start = (k == 4801);
            sample();
            if (k < 4800 && bus.rom_addr !== 13'(k)) addr_err++;
            if (k == 0) begin
                check("rs_restart_addr0", 32'(bus.rom_addr), 0);
                check("rs_flushed_wr", 32'(bus.fifo_wr_en), 0);
            end
            if (k == 1) check("rs_no_stale_wr", 32'(bus.fifo_wr_en), 0);
            if (k == 2) check("rs_first_data", 32'(bus.fifo_din), 32'(rom_word(13'd0)));
            if (k == 4801) begin
                check("rs_final_no_done", 32'(bus.frame_done), 0);
                check("rs_final_busy", 32'(bus.busy), 1);
            end
            adv();
        end
        check("rs_frame_addr_errs", 32'(addr_err), 0);
        check("rs_frame_data_errs", 32'(wr_err), 0);
        check("rs_no_done_aborted", 32'(done_cnt), 0);

        // Frame started by the restart above runs to completion
        run_plain("f5");

        // Aux read while IDLE
        bus.aux_req  = 1'b1;
        bus.aux_addr = 13'd5;
        clear_mon();
        sample();
        check("idle_aux_gnt", 32'(bus.aux_gnt), 1);
        check("idle_aux_addr", 32'(bus.rom_addr), 5);
        adv();
        bus.aux_req = 1'b0;
        sample();
        check("idle_aux_no_early", 32'(bus.aux_rvalid), 0);
        check("idle_aux_addr_hold", 32'(bus.rom_addr), 5);
        adv();
        sample();
        check("idle_aux_rvalid", 32'(bus.aux_rvalid), 1);
        check("idle_aux_rdata", 32'(bus.aux_rdata), 32'(rom_word(13'd5)));
        check("idle_aux_no_fifo_wr", 32'(bus.fifo_wr_en), 0);
        adv();

        // Asynchronous reset mid-FETCH
        bus.frame_start = 1'b1;
        sample();
        adv();
        bus.frame_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            sample();
            adv();
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_fifo_wr_en", 32'(bus.fifo_wr_en), 0);
        check("arst_fifo_din", 32'(bus.fifo_din), 0);
        check("arst_rom_addr", 32'(bus.rom_addr), 0);
        check("arst_frame_done", 32'(bus.frame_done), 0);
        adv();
        rst = 1'b0;
        wr_seen   = 1'b0;
        busy_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (bus.fifo_wr_en !== 1'b0) wr_seen = 1'b1;
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
            adv();
        end
        check("arst_no_wr_after", 32'(wr_seen), 0);
        check("arst_stays_idle", 32'(busy_seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
